// File: rtl/debouncer_pkg.sv
// Shared types and constants for the debouncer bank.
// DEBOUNCER_REPEAT_EN (optional) enables auto-repeat press strobes in debounce_channel.
package debouncer_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability FSM, registered level/strobes.
// DEBOUNCER_REPEAT_EN adds a repeat counter that re-issues press while held.
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_pulse,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] repeat_delay,
  output logic             level,
  output logic             press,
  output logic             release_strobe,
  output logic             press_next
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_in;
  state_e                 state;
  logic [CNT_W-1:0]       count;
  logic                   cnt_done;
  logic                   rel_next;
  logic                   rep_fire;

  // Synchroniser idles at 1 (button released, active-low input).
  always_ff @(posedge clock or posedge reset)
    if (reset) sync <= '1;
    else       sync <= {sync[SYNC_STAGES-2:0], in_pulse};

  assign sync_in  = sync[SYNC_STAGES-1];
  assign cnt_done = count >= delay;

`ifdef DEBOUNCER_REPEAT_EN
  logic [CNT_W-1:0] rep_count;

  assign rep_fire = (repeat_delay != '0) && (rep_count >= repeat_delay - ONE);

  // Cleared outside steady PRESSED, so entry and bounce-back both restart the period.
  always_ff @(posedge clock or posedge reset)
    if (reset)                                     rep_count <= '0;
    else if (state != PRESSED || sync_in || rep_fire) rep_count <= '0;
    else if (rep_count != '1)                      rep_count <= rep_count + ONE;
`else
  logic unused_repeat;
  assign rep_fire      = 1'b0;
  assign unused_repeat = ^repeat_delay;
`endif

  always_comb begin
    press_next = 1'b0;
    rel_next   = 1'b0;
    case (state)
      PRESS_WAIT:   press_next = !sync_in && cnt_done;
      PRESSED:      press_next = !sync_in && rep_fire;
      RELEASE_WAIT: rel_next   = sync_in && cnt_done;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= RELEASED;
      count          <= '0;
      level          <= 1'b0;
      press          <= 1'b0;
      release_strobe <= 1'b0;
    end else begin
      press          <= press_next;
      release_strobe <= rel_next;
      case (state)
        RELEASED:
          if (!sync_in) begin
            state <= PRESS_WAIT;
            count <= '0;
          end
        PRESS_WAIT:
          if (sync_in) begin
            state <= RELEASED;
            count <= '0;
          end else if (cnt_done) begin
            state <= PRESSED;
            level <= 1'b1;
          end else if (count != '1) begin
            count <= count + ONE;
          end
        PRESSED:
          if (sync_in) begin
            state <= RELEASE_WAIT;
            count <= '0;
          end
        RELEASE_WAIT:
          if (!sync_in) begin
            state <= PRESSED;
          end else if (cnt_done) begin
            state <= RELEASED;
            level <= 1'b0;
          end else if (count != '1) begin
            count <= count + ONE;
          end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/debouncer_bank.sv
// CHANNELS independent debounce channels plus a registered any_press summary.
// DEBOUNCER_REPEAT_EN selects auto-repeat in every channel; release is a keyword, hence release_strobe.
module debouncer_bank
  import debouncer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in_pulse,
  input  logic [CNT_W-1:0]    delay,
  input  logic [CNT_W-1:0]    repeat_delay,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_strobe,
  output logic                any_press
);

  logic [CHANNELS-1:0] press_next;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(.CNT_W(CNT_W)) u_ch (
      .clock          (clock),
      .reset          (reset),
      .in_pulse       (in_pulse[g]),
      .delay          (delay),
      .repeat_delay   (repeat_delay),
      .level          (level[g]),
      .press          (press[g]),
      .release_strobe (release_strobe[g]),
      .press_next     (press_next[g])
    );
  end

  // Built from the channels' next-press terms so it lines up with press.
  always_ff @(posedge clock or posedge reset)
    if (reset) any_press <= 1'b0;
    else       any_press <= |press_next;

endmodule

// File: tb/tb_debouncer_bank.sv
// Bench for debouncer_bank: latency table, directed corner sequences, random run vs run-length model.
// Honours DEBOUNCER_REPEAT_EN for the auto-repeat expectations.
module tb_debouncer_bank;
  localparam int CH = 4;
  localparam int CW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] in_pulse;
  logic [CW-1:0] delay, repeat_delay;
  logic [CH-1:0] level, press, release_strobe;
  logic          any_press;

  debouncer_bank #(.CHANNELS(CH), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .in_pulse(in_pulse), .delay(delay),
    .repeat_delay(repeat_delay), .level(level), .press(press),
    .release_strobe(release_strobe), .any_press(any_press)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0, n, cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a channel flips its level once the synchronised input has disagreed
  // with it for delay+2 consecutive edges; held presses repeat every repeat_delay edges.
  logic [CH-1:0] m_s1, m_s2, m_level, m_press, m_rel;
  logic          m_any;
  longint unsigned m_run[CH], m_hold[CH];

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_level = '0; m_press = '0; m_rel = '0; m_any = 1'b0;
    for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_hold[c] = 0; end
  endtask

  task automatic model_edge();
    logic pushed, bounced;
    if (reset) begin model_reset(); return; end
    for (int c = 0; c < CH; c++) begin
      pushed = !m_s2[c];
      m_press[c] = 1'b0; m_rel[c] = 1'b0;
      if (pushed != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] >= 2 && m_run[c] - 2 >= 64'(delay)) begin
          m_level[c] = pushed;
          if (pushed) m_press[c] = 1'b1; else m_rel[c] = 1'b1;
          m_run[c] = 0; m_hold[c] = 0;
        end
      end else begin
        bounced  = m_run[c] != 0;
        m_run[c] = 0;
`ifdef DEBOUNCER_REPEAT_EN
        if (m_level[c]) begin
          if (bounced) m_hold[c] = 0;
          else begin
            m_hold[c]++;
            if (repeat_delay != 0 && m_hold[c] >= 64'(repeat_delay)) begin
              m_press[c] = 1'b1; m_hold[c] = 0;
            end
          end
        end
`else
        if (bounced) m_hold[c] = 0;
`endif
      end
    end
    m_any = |m_press;
    m_s2 = m_s1; m_s1 = in_pulse;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("model", {level, press, release_strobe, any_press}, {m_level, m_press, m_rel, m_any});
  endtask

  task automatic release_all();
    in_pulse = '1; n = 0;
    do begin step(); n++; end while (level != '0 && n < 60);
    check("release_all", level, '0);
  endtask

  typedef struct {
    logic [CH-1:0] mask;
    int unsigned   dly;
    int unsigned   lat;  // edges from the sampling edge to the strobe, inclusive
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'b0001, 5, 9};
    vecs[1] = '{4'b1001, 0, 4};
    vecs[2] = '{4'b0110, 1, 5};
    vecs[3] = '{4'b1111, 3, 7};
    vecs[4] = '{4'b0100, 2, 6};
    vecs[5] = '{4'b1010, 7, 11};

    reset = 1'b1; in_pulse = '1; delay = 5; repeat_delay = 0;
    model_reset();
    repeat (3) step();
    check("reset_state", {level, press, release_strobe, any_press}, '0);
    reset = 1'b0;

    // Latency and mask table
    for (int v = 0; v < 6; v++) begin
      delay = vecs[v].dly;
      in_pulse = ~vecs[v].mask; n = 0;
      do begin step(); n++; end while (press == '0 && n < 40);
      check("press_latency", n, vecs[v].lat);
      check("press_mask", press, vecs[v].mask);
      check("press_any", any_press, 1'b1);
      step();
      check("press_width", press, '0);
      check("level_set", level, vecs[v].mask);
      in_pulse = '1; n = 0;
      do begin step(); n++; end while (release_strobe == '0 && n < 40);
      check("release_latency", n, vecs[v].lat);
      check("release_mask", release_strobe, vecs[v].mask);
      check("release_level", level, '0);
      step();
      check("release_width", release_strobe, '0);
    end

    // Bounce on ch1 every 3 cycles, then settle low
    delay = 5;
    for (int i = 0; i < 30; i++) begin
      in_pulse = '1; in_pulse[1] = ((i / 3) % 2) != 0;
      step();
      check("bounce_quiet", {press, release_strobe}, '0);
    end
    in_pulse[1] = 1'b0; n = 0;
    do begin step(); n++; end while (press == '0 && n < 40);
    check("bounce_settle", n, 9);
    check("bounce_mask", press, 4'b0010);
    release_all();

    // Reset during RELEASE_WAIT: no release strobe afterwards
    delay = 10; in_pulse[2] = 1'b0; n = 0;
    do begin step(); n++; end while (!level[2] && n < 40);
    check("rw_pressed", level[2], 1'b1);
    in_pulse[2] = 1'b1;
    repeat (4) step();
    check("rw_level_held", level[2], 1'b1);
    #2 reset = 1'b1;
    #1 check("reset_async", {level, press, release_strobe, any_press}, '0);
    model_reset();
    repeat (2) step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("rw_no_release", release_strobe, '0);
    end

    // Lowering delay mid-wait completes on the next edge
    delay = 100; in_pulse[0] = 1'b0;
    for (int i = 0; i < 53; i++) begin
      step();
      check("slow_wait_quiet", press, '0);
    end
    delay = 2;
    step();
    check("delay_lowered", press, 4'b0001);
    release_all();

    // Auto-repeat period, then single-press behaviour
    delay = 2;
`ifdef DEBOUNCER_REPEAT_EN
    repeat_delay = 4; in_pulse[0] = 1'b0; n = 0;
    do begin step(); n++; end while (press == '0 && n < 40);
    check("rep_first", n, 6);
    for (int i = 1; i <= 20; i++) begin
      step();
      check("rep_period", press[0], (i % 4) == 0);
    end
    release_all();
    repeat_delay = 0;
`else
    repeat_delay = 3;
`endif
    in_pulse[0] = 1'b0; cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      cnt += int'(press[0]);
    end
    check("single_press", cnt, 1);
    release_all();

    // Random run against the model
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(7) == 0) in_pulse[c] = ~in_pulse[c];
      if ($urandom_range(63) == 0) delay = $urandom_range(6);
      if ($urandom_range(63) == 0) repeat_delay = $urandom_range(5);
      reset = ($urandom_range(499) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
